fc_layer_engine: RTL

- Parametrised fully-connected layer engine: the next generation of the fixed 32-neuron layer-2 block, generalised in input length, neuron count, data width and scale.
- Integrates the address-sequencing controller, OUT_DIM parallel MAC lanes, fixed-point requantisation, optional ReLU and a valid/ready result handshake.
- Sits between an activation buffer (x) and a weight BRAM (one row per input index, OUT_DIM weights wide). Drives the next layer's input buffer.

---
 rtl/fc_layer_engine_pkg.sv | 36 +++
 rtl/fc_layer_engine_mac_lane.sv | 79 +++++++
 rtl/fc_layer_engine.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fc_layer_engine_pkg.sv
// Shared types and helpers for the fully-connected layer engine.
// Rounding of the requantised result is selected with FC_ROUND_EN.
package fc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_DRAIN = 3'd2,
      ST_SCALE = 3'd3,
      ST_HOLD  = 3'd4
   } fc_state_e;

   localparam int unsigned FC_IN_DIM_DEFAULT = 128;
   localparam int unsigned FC_ADDR_W_DEFAULT = $clog2(FC_IN_DIM_DEFAULT);

   function automatic int unsigned addr_width(input int unsigned in_dim);
      return (in_dim > 1) ? $clog2(in_dim) : 1;
   endfunction

   // Clamp a wide signed value into the range of a signed 'width'-bit word.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                   input int unsigned width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (v > hi) begin
         return hi;
      end else if (v < lo) begin
         return lo;
      end else begin
         return v;
      end
   endfunction

endpackage

// File: rtl/fc_layer_engine_mac_lane.sv
// One neuron lane: signed MAC accumulator plus scale, shift, saturate and ReLU.
// FC_ROUND_EN adds a half-LSB bias before the shift (round half up).
module fc_mac_lane
   import fc_pkg::*;
#(
   parameter int unsigned         DATA_W  = 8,
   parameter int unsigned         ACC_W   = 24,
   parameter int unsigned         COEFF_W = 17,
   parameter logic [COEFF_W-1:0]  COEFF   = 17'h000DC,
   parameter int unsigned         SHIFT   = 16
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     clr_i,
   input  logic                     acc_en_i,
   input  logic                     load_i,
   input  logic                     relu_i,
   input  logic signed [DATA_W-1:0] x_i,
   input  logic signed [DATA_W-1:0] w_i,
   output logic        [DATA_W-1:0] dout_o
);

   localparam int unsigned PROD_W = ACC_W + COEFF_W + 1;
   localparam int unsigned SUM_W  = PROD_W + 1;
   localparam int unsigned MULT_W = 2 * DATA_W;

   localparam logic signed [PROD_W-1:0] COEFF_EXT = {{(PROD_W - COEFF_W){1'b0}}, COEFF};
`ifdef FC_ROUND_EN
   localparam logic signed [SUM_W-1:0]  ROUND_BIAS = SUM_W'(1) << (SHIFT - 1);
`else
   localparam logic signed [SUM_W-1:0]  ROUND_BIAS = '0;
`endif

   logic signed [MULT_W-1:0] mult;
   logic signed [ACC_W-1:0]  mult_ext;
   logic signed [ACC_W-1:0]  acc;
   logic signed [PROD_W-1:0] acc_ext;
   logic signed [PROD_W-1:0] scaled;
   logic signed [SUM_W-1:0]  biased;
   logic signed [SUM_W-1:0]  shifted;
   logic signed [63:0]       shifted_ext;
   logic        [DATA_W-1:0] sat_q;
   logic        [DATA_W-1:0] result;

   always_comb begin
      mult     = x_i * w_i;
      mult_ext = {{(ACC_W - MULT_W){mult[MULT_W-1]}}, mult};
   end

   always_comb begin
      acc_ext     = {{(PROD_W - ACC_W){acc[ACC_W-1]}}, acc};
      scaled      = acc_ext * COEFF_EXT;
      biased      = {scaled[PROD_W-1], scaled} + ROUND_BIAS;
      shifted     = biased >>> SHIFT;
      shifted_ext = {{(64 - SUM_W){shifted[SUM_W-1]}}, shifted};
      sat_q       = DATA_W'(saturate(shifted_ext, DATA_W));
      result      = sat_q;
      if (relu_i && sat_q[DATA_W-1]) begin
         result = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         acc    <= '0;
         dout_o <= '0;
      end else begin
         if (clr_i) begin
            acc <= '0;
         end else if (acc_en_i) begin
            acc <= acc + mult_ext;
         end
         if (load_i) begin
            dout_o <= result;
         end
      end
   end

endmodule

// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: address sequencer, OUT_DIM MAC lanes, result handshake.
// Optional round-half-up requantisation is enabled by defining FC_ROUND_EN.
module fc_layer_engine
   import fc_pkg::*;
#(
   parameter int unsigned         IN_DIM  = 128,
   parameter int unsigned         OUT_DIM = 32,
   parameter int unsigned         DATA_W  = 8,
   parameter int unsigned         ACC_W   = 24,
   parameter int unsigned         COEFF_W = 17,
   parameter logic [COEFF_W-1:0]  COEFF   = 17'h000DC,
   parameter int unsigned         SHIFT   = 16
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic                          start_i,
   input  logic                          relu_en_i,
   output logic                          busy_o,
   output logic [$clog2(IN_DIM)-1:0]     x_addr_o,
   output logic                          x_en_o,
   input  logic signed [DATA_W-1:0]      x_data_i,
   output logic [$clog2(IN_DIM)-1:0]     w_addr_o,
   output logic                          w_en_o,
   input  logic [OUT_DIM*DATA_W-1:0]     w_data_i,
   output logic [OUT_DIM*DATA_W-1:0]     dout_o,
   output logic                          dout_valid_o,
   input  logic                          dout_ready_i,
   output logic                          done_o
);

   localparam int unsigned       ADDR_W    = addr_width(IN_DIM);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IN_DIM - 1);

   fc_state_e         state;
   logic [ADDR_W-1:0] addr;
   logic              x_en;
   logic              en_d;
   logic              relu_q;
   logic              dout_valid;
   logic              clr;
   logic              load;

   always_comb begin
      clr          = (state == ST_IDLE) && start_i;
      load         = (state == ST_SCALE);
      busy_o       = (state != ST_IDLE);
      x_addr_o     = addr;
      w_addr_o     = addr;
      x_en_o       = x_en;
      w_en_o       = x_en;
      dout_valid_o = dout_valid;
      done_o       = dout_valid & dout_ready_i;
   end

   // Enables are registered so that address k is presented in the cycle after the
   // address k-1; en_d marks the cycle in which the memory data for that read is valid.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state      <= ST_IDLE;
         addr       <= '0;
         x_en       <= 1'b0;
         en_d       <= 1'b0;
         relu_q     <= 1'b0;
         dout_valid <= 1'b0;
      end else begin
         en_d <= x_en;
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  state  <= ST_FETCH;
                  x_en   <= 1'b1;
                  addr   <= '0;
                  relu_q <= relu_en_i;
               end
            end
            ST_FETCH: begin
               if (addr == LAST_ADDR) begin
                  x_en  <= 1'b0;
                  addr  <= '0;
                  state <= ST_DRAIN;
               end else begin
                  addr <= addr + ADDR_W'(1);
               end
            end
            ST_DRAIN: begin
               state <= ST_SCALE;
            end
            ST_SCALE: begin
               state      <= ST_HOLD;
               dout_valid <= 1'b1;
            end
            ST_HOLD: begin
               if (dout_ready_i) begin
                  dout_valid <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   for (genvar n = 0; n < OUT_DIM; n++) begin : g_lane
      fc_mac_lane #(
         .DATA_W  (DATA_W),
         .ACC_W   (ACC_W),
         .COEFF_W (COEFF_W),
         .COEFF   (COEFF),
         .SHIFT   (SHIFT)
      ) u_lane (
         .clk_i    (clk_i),
         .rstn_i   (rstn_i),
         .clr_i    (clr),
         .acc_en_i (en_d),
         .load_i   (load),
         .relu_i   (relu_q),
         .x_i      (x_data_i),
         .w_i      (w_data_i[n*DATA_W +: DATA_W]),
         .dout_o   (dout_o[n*DATA_W +: DATA_W])
      );
   end

endmodule
